// File: rtl/i2s_mic_ctrl.sv
// i2s_mic_ctrl: I2S microphone receive sequencer. It owns the clock generator reset, discards warm-up frames, then deserialises one channel.
// Latency: sample_valid rises 1 clk after the bclk_falling strobe that completes the sample.
// Backpressure: one-deep holding register. A completion that finds it full and not draining is dropped and sets sticky overrun.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   enable             level run/stop request
//   bclk_falling       single-cycle strobe from the clock generator
//   lrclk, sd          word select (pre-update value in the strobe cycle) and mic serial data
//   clkgen_rst_n       active-low reset driven to the clock generator
//   sample/_valid/_ready  one-deep valid/ready output holding register
//   overrun            sticky: a completed sample was dropped
//   streaming          1 while samples are delivered downstream
module i2s_mic_ctrl #(
    parameter int SAMPLE_BITS   = 24,
    parameter int WARMUP_FRAMES = 4096,
    parameter int CHANNEL       = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   bclk_falling,
    input  logic                   lrclk,
    input  logic                   sd,
    output logic                   clkgen_rst_n,
    output logic [SAMPLE_BITS-1:0] sample,
    output logic                   sample_valid,
    input  logic                   sample_ready,
    output logic                   overrun,
    output logic                   streaming
);
    localparam int             WCW       = $clog2(WARMUP_FRAMES + 1);
    localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_FRAMES - 1);
    localparam logic [WCW-1:0] WARM_DONE = WCW'(WARMUP_FRAMES);
    localparam logic [4:0]     POS_MAX   = 5'd31;
    localparam logic [4:0]     POS_LAST  = 5'(SAMPLE_BITS);
    localparam logic           CH        = 1'(CHANNEL);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_STREAM
    } state_t;

    state_t                 state;
    logic                   lrclk_prev;
    logic [4:0]             pos;
    logic [WCW-1:0]         warm_cnt;
    logic [SAMPLE_BITS-1:0] shreg;

    logic [4:0]             cur_pos;
    logic                   slot_edge;
    logic                   frame_start;
    logic                   in_slot;
    logic                   capture;
    logic                   complete;
    logic                   drain;
    logic [SAMPLE_BITS-1:0] shift_next;

    // Position of the strobe in the current cycle, derived from the
    // pre-update lrclk and the position stored at the previous strobe.
    always_comb begin
        slot_edge = (lrclk != lrclk_prev);
        if (slot_edge) begin
            cur_pos = 5'd0;
        end else if (pos == POS_MAX) begin
            cur_pos = POS_MAX;
        end else begin
            cur_pos = pos + 5'd1;
        end
        // A frame begins at the left slot, i.e. a 1->0 change of lrclk.
        frame_start = bclk_falling && slot_edge && !lrclk;
        in_slot     = (lrclk == CH) && (cur_pos != 5'd0) && (cur_pos <= POS_LAST);
        capture     = (state == ST_STREAM) && bclk_falling && in_slot;
        complete    = capture && (cur_pos == POS_LAST);
        // Cast truncation keeps this legal for a 1-bit sample as well.
        shift_next  = SAMPLE_BITS'({shreg, sd});
        drain       = sample_valid && sample_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            clkgen_rst_n <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            streaming    <= 1'b0;
            lrclk_prev   <= 1'b0;
            pos          <= 5'd0;
            warm_cnt     <= '0;
            shreg        <= '0;
        end else if (!enable) begin
            // Stop from any state: generator held in reset, partial
            // capture and the holding register discarded. overrun is
            // kept so software can still read it after stopping.
            state        <= ST_IDLE;
            clkgen_rst_n <= 1'b0;
            sample_valid <= 1'b0;
            streaming    <= 1'b0;
            lrclk_prev   <= 1'b0;
            pos          <= 5'd0;
            shreg        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state        <= ST_WARMUP;
                    clkgen_rst_n <= 1'b1;
                    overrun      <= 1'b0;
                    warm_cnt     <= '0;
                end
                default: begin
                    // Slot tracking runs in both WARMUP and STREAM so
                    // the position is valid from the first streamed slot.
                    if (bclk_falling) begin
                        lrclk_prev <= lrclk;
                        pos        <= cur_pos;
                    end

                    if (state == ST_WARMUP && frame_start) begin
                        if (warm_cnt == WARM_LAST) begin
                            state     <= ST_STREAM;
                            streaming <= 1'b1;
                            warm_cnt  <= WARM_DONE;
                        end else begin
                            warm_cnt <= warm_cnt + 1'b1;
                        end
                    end

                    if (capture) begin
                        shreg <= shift_next;
                    end

                    // A completion may refill the register in the very
                    // cycle it drains; otherwise a full register drops it.
                    if (complete && (!sample_valid || sample_ready)) begin
                        sample       <= shift_next;
                        sample_valid <= 1'b1;
                    end else begin
                        if (complete) begin
                            overrun <= 1'b1;
                        end
                        if (drain) begin
                            sample_valid <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_mic_ctrl.sv
// tb_i2s_mic_ctrl: drives two controllers (left and right channel) from a clock-generator and microphone model.
// Latency: expected load cycles are derived from the generator's strobe index, 1 clk after the completing strobe.
// Backpressure: sample_ready is driven by the directed steps, or pulsed by the generator on one chosen strobe.
module tb_i2s_mic_ctrl;
    localparam int SB  = 24;
    localparam int WF  = 2;
    localparam int NFR = 12;
    localparam int NST = 64 * NFR;
    localparam int FAR = 1 << 30;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          bclk_falling = 1'b0;
    logic          lrclk = 1'b0;
    logic          sd = 1'b0;
    logic          sample_ready = 1'b0;
    logic          crn0, crn1, v0, v1, ov0, ov1, st0, st1;
    logic [SB-1:0] s0, s1;

    i2s_mic_ctrl #(.SAMPLE_BITS(SB), .WARMUP_FRAMES(WF), .CHANNEL(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .bclk_falling(bclk_falling),
        .lrclk(lrclk), .sd(sd), .clkgen_rst_n(crn0), .sample(s0),
        .sample_valid(v0), .sample_ready(sample_ready), .overrun(ov0),
        .streaming(st0)
    );

    i2s_mic_ctrl #(.SAMPLE_BITS(SB), .WARMUP_FRAMES(WF), .CHANNEL(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .bclk_falling(bclk_falling),
        .lrclk(lrclk), .sd(sd), .clkgen_rst_n(crn1), .sample(s1),
        .sample_valid(v1), .sample_ready(sample_ready), .overrun(ov1),
        .streaming(st1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [SB-1:0] wl [NFR];
    logic [SB-1:0] wr [NFR];
    int            strobe_cyc [NST];
    int            gen_k = 0;
    int            div = 0;
    bit            idle_noise = 1'b0;
    bit            pulse_mode = 1'b0;
    int            pulse_k = -1;

    // Clock generator + microphone: one strobe every 8 clk. Strobe k
    // belongs to frame k/64, slot (k/32)%2, slot position k%32; bits
    // 1..SB carry the word MSB first, all other positions carry junk.
    always @(posedge clk) begin
        int f, c, p;
        logic [SB-1:0] w;
        #2;
        if (!crn0) begin
            div   = 0;
            gen_k = 0;
            if (idle_noise) begin
                bclk_falling = 1'($urandom);
                lrclk        = 1'($urandom);
                sd           = 1'($urandom);
            end else begin
                bclk_falling = 1'b0;
                lrclk        = 1'b0;
                sd           = 1'b0;
            end
        end else if (div == 7) begin
            div = 0;
            f = gen_k / 64;
            c = (gen_k / 32) % 2;
            p = gen_k % 32;
            if (f < NFR) w = (c == 1) ? wr[f] : wl[f];
            else         w = SB'($urandom);
            lrclk = 1'(c);
            if (p >= 1 && p <= SB) sd = w[SB-p];
            else                   sd = 1'($urandom);
            bclk_falling = 1'b1;
            if (gen_k < NST) strobe_cyc[gen_k] = cyc;
            if (pulse_mode) sample_ready = (gen_k == pulse_k);
            gen_k++;
        end else begin
            div++;
            bclk_falling = 1'b0;
            if (pulse_mode) sample_ready = 1'b0;
        end
    end

    // Load monitor: a load is valid high after being low, or valid still
    // high right after an accepting cycle.
    int            ld0_c[$], ld1_c[$];
    logic [SB-1:0] ld0_v[$], ld1_v[$];
    logic          pv0 = 1'b0, pa0 = 1'b0, pv1 = 1'b0, pa1 = 1'b0;
    always @(negedge clk) begin
        if (v0 && (!pv0 || pa0)) begin ld0_c.push_back(cyc); ld0_v.push_back(s0); end
        if (v1 && (!pv1 || pa1)) begin ld1_c.push_back(cyc); ld1_v.push_back(s1); end
        pv0 = v0; pa0 = v0 && sample_ready;
        pv1 = v1; pa1 = v1 && sample_ready;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] q0v(input int i);
        return (i < ld0_v.size()) ? 64'(ld0_v[i]) : '1;
    endfunction
    function automatic logic [63:0] q0c(input int i);
        return (i < ld0_c.size()) ? 64'(ld0_c[i]) : '1;
    endfunction
    function automatic logic [63:0] q1v(input int i);
        return (i < ld1_v.size()) ? 64'(ld1_v[i]) : '1;
    endfunction
    function automatic logic [63:0] q1c(input int i);
        return (i < ld1_c.size()) ? 64'(ld1_c[i]) : '1;
    endfunction
    function automatic logic [63:0] scyc(input int k);
        return 64'(strobe_cyc[k] + 1);
    endfunction

    task automatic clr();
        for (int i = 0; i < NST; i++) strobe_cyc[i] = FAR;
        ld0_c.delete(); ld0_v.delete(); ld1_c.delete(); ld1_v.delete();
    endtask

    task automatic drive_en(input logic en, input logic rdy);
        @(posedge clk); #1;
        enable       = en;
        sample_ready = rdy;
    endtask

    task automatic wait_loads(input int n0, input int n1, input int budget, input string tag);
        int t = 0;
        while ((ld0_c.size() < n0 || ld1_c.size() < n1) && t < budget) begin
            @(negedge clk); t++;
        end
        chk(tag, 64'((ld0_c.size() >= n0) && (ld1_c.size() >= n1)), 64'd1);
    endtask

    task automatic wait_stream(input string tag);
        int t = 0;
        while (!st0 && t < 3000) begin @(negedge clk); t++; end
        chk({tag, "_rise"}, 64'(cyc), scyc(64 * WF));
        chk({tag, "_novld"}, 64'(ld0_c.size() + ld1_c.size()), 64'd0);
    endtask

    task automatic fill_random();
        for (int f = 0; f < NFR; f++) begin
            wl[f] = SB'($urandom);
            wr[f] = SB'($urandom);
        end
    endtask

    initial begin
        int idle_err, rel, fexp;

        // Reset and idle: random strobe noise must have no effect.
        fill_random();
        clr();
        idle_noise = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 64'({crn0, v0, ov0, st0, s0, crn1, v1, ov1, st1, s1}), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        idle_err = 0;
        repeat (1000) begin
            @(negedge clk);
            if ({crn0, v0, ov0, st0, s0, crn1, v1, ov1, st1, s1} !== '0) idle_err++;
        end
        chk("idle_quiet", 64'(idle_err), 64'd0);
        idle_noise = 1'b0;

        // Warm-up and channel select, ready held high.
        for (int f = 0; f < NFR; f++) wl[f] = (f <= WF) ? 24'hA5A5A5 : SB'($urandom);
        wl[3] = 24'h123456;
        wr[3] = 24'hFEDCBA;
        clr();
        drive_en(1'b1, 1'b1);
        repeat (2) @(negedge clk);
        chk("clkgen_rise", 64'(crn0), 64'd1);
        wait_stream("warm");
        wait_loads(4, 4, 5000, "chan_loads");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("left_val%0d", i),  q0v(i), 64'(wl[WF+i]));
            chk($sformatf("left_cyc%0d", i),  q0c(i), scyc(64 * (WF + i) + SB));
            chk($sformatf("right_val%0d", i), q1v(i), 64'(wr[WF+i]));
            chk($sformatf("right_cyc%0d", i), q1c(i), scyc(64 * (WF + i) + 32 + SB));
        end

        // Backpressure: incrementing samples, ready low for 3 frames.
        drive_en(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("dis_idle", 64'({crn0, v0, st0}), 64'd0);
        for (int f = 0; f < NFR; f++) begin
            wl[f] = SB'(f - WF + 1);
            wr[f] = SB'($urandom);
        end
        clr();
        drive_en(1'b1, 1'b0);
        wait_loads(1, 0, 3000, "bp_first");
        chk("bp_first_val", q0v(0), 64'd1);
        repeat (3 * 512) @(negedge clk);
        chk("bp_hold_val", 64'(s0), 64'd1);
        chk("bp_hold_vld", 64'(v0), 64'd1);
        chk("bp_ovr", 64'(ov0), 64'd1);
        repeat ($urandom_range(0, 511)) @(negedge clk);
        @(posedge clk); #1;
        sample_ready = 1'b1;
        rel = cyc;
        wait_loads(2, 0, 1500, "bp_next");
        fexp = NFR - 1;
        for (int f = NFR - 1; f >= WF; f--)
            if (strobe_cyc[64 * f + SB] >= rel) fexp = f;
        chk("bp_next_val", q0v(1), 64'(wl[fexp]));
        chk("bp_next_cyc", q0c(1), scyc(64 * fexp + SB));
        chk("bp_ovr_kept", 64'(ov0), 64'd1);

        // Ready pulsed exactly in the completion cycle of frame WF+1.
        drive_en(1'b0, 1'b0);
        fill_random();
        clr();
        pulse_k    = 64 * (WF + 1) + SB;
        pulse_mode = 1'b1;
        drive_en(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("reen_ovr_clr", 64'(ov0), 64'd0);
        wait_loads(2, 0, 3000, "sim_loads");
        chk("sim_val0", q0v(0), 64'(wl[WF]));
        chk("sim_val1", q0v(1), 64'(wl[WF+1]));
        chk("sim_cyc1", q0c(1), scyc(pulse_k));
        chk("sim_vld",  64'(v0), 64'd1);
        chk("sim_ovr",  64'(ov0), 64'd0);
        pulse_mode = 1'b0;
        @(posedge clk); #1 sample_ready = 1'b0;

        // Disable at slot position 10 of frame WF+3 with a held sample.
        begin
            int t = 0;
            while (gen_k <= 64 * (WF + 3) + 10 && t < 2000) begin @(negedge clk); t++; end
            chk("pos10_reached", 64'(gen_k), 64'(64 * (WF + 3) + 11));
        end
        chk("pre_dis_ovr", 64'(ov0), 64'd1);
        drive_en(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("midslot_idle", 64'({v0, crn0, st0}), 64'd0);
        fill_random();
        clr();
        drive_en(1'b1, 1'b1);
        repeat (2) @(negedge clk);
        chk("re_ovr_clr", 64'(ov0), 64'd0);
        wait_stream("rewarm");
        wait_loads(2, 0, 2000, "re_loads");
        chk("re_val0", q0v(0), 64'(wl[WF]));
        chk("re_cyc0", q0c(0), scyc(64 * WF + SB));
        chk("re_val1", q0v(1), 64'(wl[WF+1]));

        // Reset mid-operation overrides enable.
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid", 64'({crn0, v0, ov0, st0, s0, crn1, v1, ov1, st1, s1}), 64'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_mic_ctrl.md
# i2s_mic_ctrl

Sequencing controller for the I2S microphone receive path. Owns the I2S clock generator's reset, enforces the microphone start-up period by discarding a configurable number of frames, and deserialises one channel of SD data. Timing comes from the generator's `bclk_falling` strobe and `lrclk`. Completed samples are delivered over a one-deep valid/ready holding register to the downstream FFT buffer.

## Interface
- `SAMPLE_BITS`, default 24: captured sample width, MSB first. Legal range 1..31.
- `WARMUP_FRAMES`, default 4096: frames discarded after enable. Legal range ≥1. At 25 MHz with clkgen divider 4, this is about 84 ms.
- `CHANNEL`, default 0: slot captured. 0 = left (`lrclk`=0), 1 = right (`lrclk`=1).
- `clk` input 1: system clock; single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: level; 1 = run, 0 = stop.
- `bclk_falling` input 1: single-cycle strobe from the clock generator.
- `lrclk` input 1: word select from the clock generator. Registered by the generator on the same edge as the strobe.
- `sd` input 1: microphone serial data, synchronised externally.
- `clkgen_rst_n` output 1: active-low reset driven to the clock generator.
- `sample` output SAMPLE_BITS: two's-complement sample, held while `sample_valid`=1.
- `sample_valid` output 1: holding register full.
- `sample_ready` input 1: downstream accepts when `sample_valid` & `sample_ready`.
- `overrun` output 1: sticky flag; a completed sample was dropped.
- `streaming` output 1: 1 in STREAM state.

## Operation
- States:
  - IDLE: `clkgen_rst_n`=0, all bit-level registers cleared.
  - WARMUP: generator running, samples discarded.
  - STREAM: samples delivered downstream.
- Transitions:
  - IDLE→WARMUP: `enable`=1. In the same transition, clear `overrun` and the warm-up counter, and set `clkgen_rst_n`=1.
  - WARMUP→STREAM: on the WARMUP_FRAMES-th frame start. That frame's slot is the first one captured.
  - Any state→IDLE: `enable`=0. Pending partial sample and `sample_valid` are cleared.
- Strobe sampling: on each `bclk_falling` cycle, sample `lrclk` and `sd` as seen in that cycle, i.e. the pre-update `lrclk`.
- Slot position:
  - `lrclk_prev` is a register updated only on strobes; reset value 0.
  - A strobe whose sampled `lrclk` ≠ `lrclk_prev` is slot position 0.
  - Each subsequent strobe increments the position; the 5-bit counter saturates at 31.
- Frame start: a position-0 strobe with sampled `lrclk`=0 (a 1→0 change). After a generator reset, the first frame start occurs on strobe 64.
- Capture:
  - In STREAM, positions 1..SAMPLE_BITS of the slot whose `lrclk` equals CHANNEL shift `sd` in, MSB first.
  - Position-0 data and positions above SAMPLE_BITS are ignored.
  - The other channel's slot is ignored.
- Completion: occurs at the position-SAMPLE_BITS strobe, with these cases:
  - Holding register empty, or drained in the same cycle: load `sample` and set `sample_valid`.
  - `sample_valid`=1 and `sample_ready`=0: drop the new sample, keep the held one, set `overrun`.
- Handshake:
  - `sample_valid` falls the cycle after acceptance, unless a completion loads in that same cycle, in which case it stays 1 with the new value.
  - `sample` is stable while `sample_valid`=1 and not accepted.
- Warm-up counter width is $clog2(WARMUP_FRAMES+1). The counter stops at WARMUP_FRAMES and does not wrap.

## Timing
- Reset values: state IDLE, `clkgen_rst_n`=0, `sample`=0, `sample_valid`=0, `overrun`=0, `streaming`=0, `lrclk_prev`=0, position=0.
- `rst` overrides `enable`. `rst` asserted mid-operation returns all outputs to reset values on the next edge.
- `clkgen_rst_n` rises the clock after `enable` is first seen high in IDLE. It falls the clock after `enable` is seen low.
- `streaming` rises the clock after the qualifying frame-start strobe.
- `sample_valid` rises the clock after the completing strobe, so the strobe-to-valid latency is 1 clk.
- Throughput: one sample per 64 strobes. With CLK_DIV=4 this is 512 clk, so ready is never required faster than that.
- `bclk_falling` while in IDLE is ignored.

## Test plan
- Reset/idle: hold `rst`=1, then `rst`=0 with `enable`=0 for 1000 clk → all outputs stay 0, including `clkgen_rst_n`, and no strobe effects.
- Warm-up: WARMUP_FRAMES=2, mic model sends left 0xA5A5A5 every frame, `sample_ready`=1 → no `sample_valid` before the 2nd frame start. `streaming` rises 1 clk after that strobe. The first sample is 0xA5A5A5, valid 1 clk after the position-24 strobe.
- Channel select: CHANNEL=0, left 0x123456, right 0xFEDCBA → only 0x123456 is delivered, at exactly 512-clk spacing. Rerun with CHANNEL=1 → only 0xFEDCBA.
- Backpressure/overrun: incrementing samples 1,2,3,…, hold `sample_ready`=0 for 3 frames → `sample` holds 1 and `overrun`=1. Release `sample_ready` → next delivered sample is the first one completing after release, with `overrun` still 1.
- Simultaneous: pulse `sample_ready` exactly in the completion cycle → `sample_valid` stays 1, new value loaded, `overrun`=0.
- Disable mid-slot: `enable`=0 at position 10 → next clk IDLE, `sample_valid`=0, `clkgen_rst_n`=0. Re-enable → `overrun` cleared, full warm-up repeated, first sample is correct and not corrupted by the partial capture.
